// File: rtl/md_issue_ctrl.sv
// Issue/completion controller in front of the RV64M multiply/divide unit.
// Optional watchdog abort is compiled in with `define MD_TIMEOUT_EN.
module md_issue_ctrl #(
    parameter int MIN_RUN = 1,
    parameter int TIMEOUT = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_word,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [4:0]  mul_op,
    output logic [3:0]  div_op,
    output logic [63:0] md_a,
    output logic [63:0] md_b,
    input  logic        md_stallreq,
    input  logic [63:0] md_result,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [63:0] out_data,
    output logic        out_illegal,
    output logic        out_timeout
);

    localparam int CNT_MAX = (TIMEOUT > MIN_RUN) ? TIMEOUT : MIN_RUN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [2:0]       funct3_q;
    logic             word_q;
    logic [CNT_W-1:0] run_cnt;

    logic [4:0]  dec_mul_op;
    logic [3:0]  dec_div_op;
    logic        dec_illegal;
    logic        is_div;
    logic [63:0] a_sext;
    logic        div_zero;
    logic        div_ovf;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign is_div   = funct3_q[2];

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        dec_mul_op  = '0;
        dec_div_op  = '0;
        dec_illegal = 1'b0;
        if (!funct3_q[2]) begin
            if (word_q) begin
                if (funct3_q[1:0] == 2'b00) dec_mul_op = 5'b00001;
                else                        dec_illegal = 1'b1;
            end else begin
                case (funct3_q[1:0])
                    2'b00:   dec_mul_op = 5'b10000;
                    2'b01:   dec_mul_op = 5'b01000;
                    2'b10:   dec_mul_op = 5'b00010;
                    default: dec_mul_op = 5'b00100;
                endcase
            end
        end else begin
            // {div, rem, signed_div, w_type}
            dec_div_op = {~funct3_q[1], funct3_q[1], ~funct3_q[0], word_q};
        end
    end

    // Special cases are judged on the effective operand width (low word for W ops).
    always_comb begin
        a_sext   = word_q ? {{32{md_a[31]}}, md_a[31:0]} : md_a;
        div_zero = word_q ? (md_b[31:0] == 32'd0) : (md_b == 64'd0);
        div_ovf  = dec_div_op[1] &&
                   (word_q ? (md_a[31:0] == 32'h8000_0000 && md_b[31:0] == 32'hFFFF_FFFF)
                           : (md_a == 64'h8000_0000_0000_0000 && md_b == {64{1'b1}}));
    end

`ifndef MD_TIMEOUT_EN
    assign out_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            funct3_q    <= '0;
            word_q      <= 1'b0;
            md_a        <= '0;
            md_b        <= '0;
            out_rd      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            mul_op      <= '0;
            div_op      <= '0;
            run_cnt     <= '0;
`ifdef MD_TIMEOUT_EN
            out_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        funct3_q <= in_funct3;
                        word_q   <= in_word;
                        md_a     <= in_rs1;
                        md_b     <= in_rs2;
                        out_rd   <= in_rd;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (dec_illegal) begin
                        out_data    <= '0;
                        out_illegal <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (is_div && div_zero) begin
                        out_data  <= dec_div_op[3] ? {64{1'b1}} : a_sext;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (is_div && div_ovf) begin
                        out_data  <= dec_div_op[3] ? a_sext : 64'd0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mul_op  <= dec_mul_op;
                        div_op  <= dec_div_op;
                        run_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (run_cnt != {CNT_W{1'b1}}) run_cnt <= run_cnt + 1'b1;
                    if (flush) begin
                        // Keep the ops up so m_top is not abandoned mid-operation.
                        state <= DRAIN;
                    end else if (run_cnt >= CNT_W'(MIN_RUN) && !md_stallreq) begin
                        out_data  <= md_result;
                        out_valid <= 1'b1;
                        mul_op    <= '0;
                        div_op    <= '0;
                        state     <= DONE;
                    end
`ifdef MD_TIMEOUT_EN
                    else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                        out_data    <= '0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        mul_op      <= '0;
                        div_op      <= '0;
                        state       <= DONE;
                    end
`endif
                end
                DRAIN: begin
                    if (!md_stallreq) begin
                        mul_op <= '0;
                        div_op <= '0;
                        state  <= IDLE;
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid   <= 1'b0;
                        out_illegal <= 1'b0;
`ifdef MD_TIMEOUT_EN
                        out_timeout <= 1'b0;
`endif
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl with a behavioural m_top stall/result model.
module tb_md_issue_ctrl;
`ifdef MD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 127;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_word;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [4:0]  in_rd;
    logic        flush;
    logic [4:0]  mul_op;
    logic [3:0]  div_op;
    logic [63:0] md_a;
    logic [63:0] md_b;
    logic        md_stallreq;
    logic [63:0] md_result;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_illegal;
    logic        out_timeout;

    md_issue_ctrl #(.MIN_RUN(1), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .flush(flush), .mul_op(mul_op), .div_op(div_op),
        .md_a(md_a), .md_b(md_b), .md_stallreq(md_stallreq), .md_result(md_result),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_illegal(out_illegal), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        illegal;
        logic        timeout;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [8:0] exp_ops_r = '0;
    int         stall_req = 0;
    logic       stuck = 1'b0;
    int         ops_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stand-in m_top result: real product for mul, otherwise a mix that exposes operand/op errors.
    function automatic logic [63:0] model_result(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [4:0] mop, input logic [3:0] dop);
        if (mop == 5'b10000) return a * b;
        return a ^ {b[31:0], b[63:32]} ^ {55'd0, mop, dop};
    endfunction

    // m_top model: stalls stall_req cycles (or forever while stuck), then returns its result.
    initial begin
        int stall_cnt;
        stall_cnt   = 0;
        md_stallreq = 1'b0;
        md_result   = '0;
        forever begin
            @(negedge clk);
            if ({mul_op, div_op} != 9'd0) begin
                ops_count++;
                check("ops_stable", {55'd0, mul_op, div_op}, {55'd0, exp_ops_r});
                if (stuck || stall_cnt < stall_req) begin
                    md_stallreq = 1'b1;
                    stall_cnt++;
                end else begin
                    md_stallreq = 1'b0;
                    md_result   = model_result(md_a, md_b, mul_op, div_op);
                end
            end else begin
                md_stallreq = 1'b0;
                stall_cnt   = 0;
            end
        end
    end

    // Writeback monitor: pops the scoreboard on every completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    check("out_illegal", {63'd0, out_illegal}, {63'd0, e.illegal});
                    check("out_timeout", {63'd0, out_timeout}, {63'd0, e.timeout});
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp_data,
                         input logic exp_ill, input logic exp_to, input logic [8:0] exp_ops,
                         input int stall, input int exp_lat, input int hold);
        int lat;
        int ops_before;
        exp_ops_r  = exp_ops;
        stall_req  = stall;
        ops_before = ops_count;
        @(negedge clk);
        check("in_ready", {63'd0, in_ready}, 64'd1);
        in_funct3 = f3;
        in_word   = w;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = rd;
        in_valid  = 1'b1;
        sb_q.push_back('{rd: rd, data: exp_data, illegal: exp_ill, timeout: exp_to});
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("ops_issued", {63'd0, ops_count != ops_before}, {63'd0, exp_ops != 9'd0});
        check("ops_clear", {55'd0, mul_op, div_op}, 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_data", out_data, exp_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", {63'd0, out_valid}, 64'd0);
        check("idle_ready", {63'd0, in_ready}, 64'd1);
    endtask

    // Normal path: RUN lasts max(stall, MIN_RUN) + 1 cycles.
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [8:0] ops,
                          input int stall);
        int run;
        run = ((stall > 1) ? stall : 1) + 1;
        issue(f3, w, a, b, rd, model_result(a, b, ops[8:4], ops[3:0]), 1'b0, 1'b0, ops,
              stall, 2 + run, 0);
    endtask

    task automatic special(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [63:0] data,
                           input logic ill);
        issue(f3, w, a, b, rd, data, ill, 1'b0, 9'd0, 0, 2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_word = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ops", {55'd0, mul_op, div_op}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        rst = 1'b0;

        // mul 7*6 with a 3-cycle stall, out_valid held 2 cycles under backpressure
        issue(3'b000, 1'b0, 64'd7, 64'd6, 5'd5, 64'd42, 1'b0, 1'b0, 9'b10000_0000, 3, 6, 2);

        // remaining decodes through the normal path
        run_op(3'b001, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd1, 9'b01000_0000, 0);
        run_op(3'b010, 1'b0, 64'hFFFF_0000_1111_2222, 64'h0000_0003_0000_0005, 5'd2, 9'b00010_0000, 2);
        run_op(3'b011, 1'b0, 64'hAAAA_5555_AAAA_5555, 64'h0000_0000_0000_0009, 5'd3, 9'b00100_0000, 1);
        run_op(3'b000, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0002_0000_0004, 5'd4, 9'b00001_0000, 5);
        run_op(3'b100, 1'b0, 64'd100, 64'h0000_0001_0000_0000, 5'd6, 9'b00000_1010, 1);
        run_op(3'b101, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd7, 9'b00000_1000, 2);
        run_op(3'b110, 1'b0, 64'd100, 64'd7, 5'd8, 9'b00000_0110, 0);
        run_op(3'b111, 1'b0, 64'd100, 64'd7, 5'd9, 9'b00000_0100, 1);
        run_op(3'b100, 1'b1, 64'd100, 64'd7, 5'd10, 9'b00000_1011, 1);
        run_op(3'b101, 1'b1, 64'd100, 64'd7, 5'd11, 9'b00000_1001, 2);
        run_op(3'b110, 1'b1, 64'd100, 64'd7, 5'd12, 9'b00000_0111, 0);
        run_op(3'b111, 1'b1, 64'd100, 64'd7, 5'd13, 9'b00000_0101, 3);

        // divide by zero
        special(3'b100, 1'b1, 64'h1234, 64'd0, 5'd14, {64{1'b1}}, 1'b0);
        special(3'b100, 1'b1, 64'h1234, 64'h0000_0001_0000_0000, 5'd15, {64{1'b1}}, 1'b0);
        special(3'b101, 1'b0, 64'h55, 64'd0, 5'd16, {64{1'b1}}, 1'b0);
        special(3'b111, 1'b0, 64'hDEAD_BEEF_0000_1111, 64'd0, 5'd17, 64'hDEAD_BEEF_0000_1111, 1'b0);
        special(3'b111, 1'b1, 64'h0000_0000_8765_4321, 64'd0, 5'd18, 64'hFFFF_FFFF_8765_4321, 1'b0);

        // signed overflow
        special(3'b100, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd19, 64'h8000_0000_0000_0000, 1'b0);
        special(3'b110, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd20, 64'd0, 1'b0);
        special(3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd21, 64'd0, 1'b0);
        special(3'b100, 1'b1, 64'hABCD_0000_8000_0000, 64'h1234_5678_FFFF_FFFF, 5'd22,
                64'hFFFF_FFFF_8000_0000, 1'b0);

        // undefined W encodings
        special(3'b010, 1'b1, 64'd9, 64'd3, 5'd23, 64'd0, 1'b1);
        special(3'b001, 1'b1, 64'd9, 64'd3, 5'd24, 64'd0, 1'b1);
        special(3'b011, 1'b1, 64'd9, 64'd0, 5'd25, 64'd0, 1'b1);

        // flush during RUN with m_top busy: DRAIN keeps ops until the stall clears
        exp_ops_r = 9'b10000_0000;
        stuck     = 1'b1;
        @(negedge clk);
        in_funct3 = 3'b000; in_word = 1'b0; in_rs1 = 64'd3; in_rs2 = 64'd4; in_rd = 5'd26;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("run_ops", {55'd0, mul_op, div_op}, {55'd0, exp_ops_r});
        @(negedge clk);
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) flush = 1'b0;
            check("drain_busy", {63'd0, busy}, 64'd1);
            check("drain_ops", {55'd0, mul_op, div_op}, {55'd0, exp_ops_r});
            check("drain_valid", {63'd0, out_valid}, 64'd0);
        end
        stuck = 1'b0;
        @(posedge clk); #1;
        check("drain_exit_busy", {63'd0, busy}, 64'd0);
        check("drain_exit_ops", {55'd0, mul_op, div_op}, 64'd0);
        check("drain_exit_valid", {63'd0, out_valid}, 64'd0);

        // flush in DONE drops out_valid without a handshake
        @(negedge clk);
        in_funct3 = 3'b100; in_word = 1'b1; in_rs1 = 64'h1234; in_rs2 = 64'd0; in_rd = 5'd27;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("done_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_valid", {63'd0, out_valid}, 64'd0);
        check("flush_done_ready", {63'd0, in_ready}, 64'd1);

        // flush has priority over acceptance in IDLE
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", {63'd0, busy}, 64'd0);

`ifdef MD_TIMEOUT_EN
        // watchdog: m_top never releases, abort after TIMEOUT RUN cycles
        stuck = 1'b1;
        issue(3'b000, 1'b0, 64'd5, 64'd5, 5'd28, 64'd0, 1'b0, 1'b1, 9'b10000_0000, 0,
              2 + TB_TIMEOUT, 0);
        stuck = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
